// File: rtl/mdr_pkg.sv
// ----------------------------------------------------------------------------
// mdr_pkg
// Shared definitions for the memory data register with handshake:
//   - transaction state encoding (IDLE / RD / WR)
//   - reset polarity constant (reset is active-low)
// ----------------------------------------------------------------------------
package mdr_pkg;

    localparam logic [1:0] MDR_IDLE = 2'd0;
    localparam logic [1:0] MDR_RD   = 2'd1;
    localparam logic [1:0] MDR_WR   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = MDR_IDLE,
        S_RD   = MDR_RD,
        S_WR   = MDR_WR
    } mdr_state_t;

    // Level of rst that holds the block in reset.
    localparam logic MDR_RST_ACTIVE = 1'b0;

endpackage

// File: rtl/mdr_timeout_cnt.sv
// ----------------------------------------------------------------------------
// mdr_timeout_cnt
// Wait-state counter for one memory transfer. Counts cycles in which a
// request is outstanding without an acknowledge, saturating at TIMEOUT-1.
// o_expire flags that the counter sits at its limit; the caller combines it
// with the acknowledge to decide on an abort. TIMEOUT=0 disables expiry.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous reset, active-low
//   i_clr    : clear the counter (held while no transfer is in progress)
//   i_en     : count this cycle (request high, no acknowledge)
//   o_expire : counter equals TIMEOUT-1 (never set when TIMEOUT=0)
// ----------------------------------------------------------------------------
module mdr_timeout_cnt
    import mdr_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    // With TIMEOUT=0 the limit is 0, so the counter never leaves 0 and
    // expiry is masked off below.
    localparam logic [CNT_WIDTH-1:0] LIMIT =
        (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);
    localparam logic TO_ENABLED = (TIMEOUT != 0);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst == MDR_RST_ACTIVE) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = TO_ENABLED && (r_cnt == LIMIT);

endmodule

// File: rtl/mdr_handshake.sv
// ----------------------------------------------------------------------------
// mdr_handshake
// Memory data register that runs its own req/ack memory transaction.
// Holds a write word (captured from busALU on wr_start) and a read word
// (captured from mem_rdata on ack), drives bus C, and reports busy/done/err.
//
// Ports:
//   clk, rst             : clock, synchronous active-low reset
//   rd_start, wr_start   : start a read / write (only accepted when idle,
//                          write wins when both are high)
//   mdr_alu_n            : bus C select, 1 = read register, 0 = busALU
//   busALU               : ALU result bus
//   busC                 : datapath bus C
//   mem_rdata, mem_ack   : memory read data and transfer acknowledge
//   mem_req, mem_we      : transfer request and direction (1 = write)
//   mem_wdata            : write register contents
//   busy                 : transaction in progress
//   done, err            : one-cycle completion / timeout-abort pulses
// ----------------------------------------------------------------------------
module mdr_handshake
    import mdr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_start,
    input  logic                  wr_start,
    input  logic                  mdr_alu_n,
    input  logic [DATA_WIDTH-1:0] busALU,
    output logic [DATA_WIDTH-1:0] busC,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    mdr_state_t            r_state;
    mdr_state_t            w_next;
    logic [DATA_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_wr;
    logic                  r_done;
    logic                  r_err;
    logic                  w_done_nxt;
    logic                  w_err_nxt;
    logic                  w_cap_rd;
    logic                  w_cap_wr;
    logic                  w_expire;

    // The counter is held clear whenever idle, so each transfer starts at 0.
    mdr_timeout_cnt #(
        .TIMEOUT   (TIMEOUT),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tocnt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (r_state == S_IDLE),
        .i_en     (mem_req && !mem_ack),
        .o_expire (w_expire)
    );

    always_comb begin
        w_next     = r_state;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        w_cap_rd   = 1'b0;
        w_cap_wr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wr_start) begin
                    w_next   = S_WR;
                    w_cap_wr = 1'b1;
                end else if (rd_start) begin
                    w_next = S_RD;
                end
            end
            S_RD, S_WR: begin
                // Acknowledge takes precedence over a same-cycle expiry.
                if (mem_ack) begin
                    w_next     = S_IDLE;
                    w_done_nxt = 1'b1;
                    w_cap_rd   = (r_state == S_RD);
                end else if (w_expire) begin
                    w_next    = S_IDLE;
                    w_err_nxt = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == MDR_RST_ACTIVE) begin
            r_state <= S_IDLE;
            r_rd    <= '0;
            r_wr    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_cap_rd) r_rd <= mem_rdata;
            if (w_cap_wr) r_wr <= busALU;
        end
    end

    assign mem_req   = (r_state != S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign mem_we    = (r_state == S_WR);
    assign mem_wdata = r_wr;
    assign done      = r_done;
    assign err       = r_err;
    assign busC      = mdr_alu_n ? r_rd : busALU;

endmodule

// File: tb/tb_mdr_handshake.sv
// ----------------------------------------------------------------------------
// tb_mdr_handshake
// Self-checking bench for mdr_handshake (DATA_WIDTH=8, TIMEOUT=4).
// Inputs change on the falling edge; outputs are observed on the falling
// edge, half a cycle after the rising edge that updated them.
// Status vector compared as {mem_req, mem_we, busy, done, err}.
// ----------------------------------------------------------------------------
module tb_mdr_handshake;

    localparam int DW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_start, wr_start, mdr_alu_n, mem_ack;
    logic [DW-1:0] busALU, mem_rdata;
    logic [DW-1:0] busC, mem_wdata;
    logic          mem_req, mem_we, busy, done, err;
    logic [4:0]    st;

    int n_tests = 0;
    int n_fail  = 0;

    mdr_handshake #(.DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_start  (rd_start),
        .wr_start  (wr_start),
        .mdr_alu_n (mdr_alu_n),
        .busALU    (busALU),
        .busC      (busC),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;
    assign st = {mem_req, mem_we, busy, done, err};

    task automatic test_reset();
        rst = 1'b0; rd_start = 0; wr_start = 0; mem_ack = 0;
        mdr_alu_n = 1; busALU = 8'h00; mem_rdata = 8'h00;
        repeat (2) @(negedge clk);
        n_tests++; if (st !== 5'b00000) begin n_fail++; $display("FAIL reset_status got=%b exp=%b", st, 5'b00000); end
        n_tests++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata got=%h exp=00", mem_wdata); end
        rst = 1'b1;
        busALU = 8'h11; wr_start = 1;
        @(negedge clk);
        wr_start = 0;
        n_tests++; if (st !== 5'b11100) begin n_fail++; $display("FAIL reset_prewrite got=%b exp=%b", st, 5'b11100); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (st !== 5'b00000) begin n_fail++; $display("FAIL reset_midwrite got=%b exp=%b", st, 5'b00000); end
        n_tests++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mid_wdata got=%h exp=00", mem_wdata); end
        n_tests++; if (busC !== 8'h00) begin n_fail++; $display("FAIL reset_busC got=%h exp=00", busC); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (st !== 5'b00000) begin n_fail++; $display("FAIL reset_release got=%b exp=%b", st, 5'b00000); end
    endtask

    task automatic test_read();
        rd_start = 1; mdr_alu_n = 1;
        @(negedge clk);
        rd_start = 0;
        n_tests++; if (st !== 5'b10100) begin n_fail++; $display("FAIL read_req got=%b exp=%b", st, 5'b10100); end
        mem_ack = 1; mem_rdata = 8'hA5;
        @(negedge clk);
        mem_ack = 0; mem_rdata = 8'h00;
        n_tests++; if (st !== 5'b00010) begin n_fail++; $display("FAIL read_done got=%b exp=%b", st, 5'b00010); end
        n_tests++; if (busC !== 8'hA5) begin n_fail++; $display("FAIL read_busC_rd got=%h exp=a5", busC); end
        mdr_alu_n = 0; busALU = 8'h3C; #1;
        n_tests++; if (busC !== 8'h3C) begin n_fail++; $display("FAIL read_busC_alu got=%h exp=3c", busC); end
        mdr_alu_n = 1;
        @(negedge clk);
        n_tests++; if (st !== 5'b00000) begin n_fail++; $display("FAIL read_done_once got=%b exp=%b", st, 5'b00000); end
    endtask

    task automatic test_write();
        busALU = 8'h5A; wr_start = 1;
        @(negedge clk);
        wr_start = 0; busALU = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (st !== 5'b11100) begin n_fail++; $display("FAIL write_req[%0d] got=%b exp=%b", i, st, 5'b11100); end
            n_tests++; if (mem_wdata !== 8'h5A) begin n_fail++; $display("FAIL write_wdata[%0d] got=%h exp=5a", i, mem_wdata); end
            mem_ack = (i == 3);
            @(negedge clk);
        end
        mem_ack = 0;
        n_tests++; if (st !== 5'b00010) begin n_fail++; $display("FAIL write_done got=%b exp=%b", st, 5'b00010); end
        n_tests++; if (busC !== 8'hA5) begin n_fail++; $display("FAIL write_rd_kept got=%h exp=a5", busC); end
        n_tests++; if (mem_wdata !== 8'h5A) begin n_fail++; $display("FAIL write_wdata_after got=%h exp=5a", mem_wdata); end
    endtask

    task automatic test_timeout();
        rd_start = 1; mem_rdata = 8'h77;
        @(negedge clk);
        rd_start = 0;
        for (int i = 0; i < TO; i++) begin
            n_tests++; if (st !== 5'b10100) begin n_fail++; $display("FAIL timeout_wait[%0d] got=%b exp=%b", i, st, 5'b10100); end
            @(negedge clk);
        end
        n_tests++; if (st !== 5'b00001) begin n_fail++; $display("FAIL timeout_err got=%b exp=%b", st, 5'b00001); end
        n_tests++; if (busC !== 8'hA5) begin n_fail++; $display("FAIL timeout_rd_kept got=%h exp=a5", busC); end
        @(negedge clk);
        n_tests++; if (st !== 5'b00000) begin n_fail++; $display("FAIL timeout_err_once got=%b exp=%b", st, 5'b00000); end
    endtask

    task automatic test_ack_at_limit();
        rd_start = 1;
        @(negedge clk);
        rd_start = 0;
        for (int i = 0; i < TO; i++) begin
            n_tests++; if (st !== 5'b10100) begin n_fail++; $display("FAIL limit_wait[%0d] got=%b exp=%b", i, st, 5'b10100); end
            mem_ack = (i == TO - 1); mem_rdata = 8'hC3;
            @(negedge clk);
        end
        mem_ack = 0;
        n_tests++; if (st !== 5'b00010) begin n_fail++; $display("FAIL limit_done got=%b exp=%b", st, 5'b00010); end
        n_tests++; if (busC !== 8'hC3) begin n_fail++; $display("FAIL limit_rd got=%h exp=c3", busC); end
    endtask

    task automatic test_both_start();
        int n_done;
        int n_req;
        busALU = 8'h96; rd_start = 1; wr_start = 1;
        @(negedge clk);
        wr_start = 0; rd_start = 1;
        n_tests++; if (st !== 5'b11100) begin n_fail++; $display("FAIL both_is_write got=%b exp=%b", st, 5'b11100); end
        n_tests++; if (mem_wdata !== 8'h96) begin n_fail++; $display("FAIL both_wdata got=%h exp=96", mem_wdata); end
        @(negedge clk);
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0; rd_start = 0;
        n_done = int'(done); n_req = 0;
        repeat (3) begin
            @(negedge clk);
            n_done += int'(done); n_req += int'(mem_req);
        end
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL both_done_count got=%0d exp=1", n_done); end
        n_tests++; if (n_req !== 0) begin n_fail++; $display("FAIL busy_start_queued got=%0d exp=0", n_req); end
        n_tests++; if (busC !== 8'hC3) begin n_fail++; $display("FAIL both_rd_kept got=%h exp=c3", busC); end
    endtask

    // Transaction-level reference: a transfer acknowledged on its k-th
    // request cycle (0-based) succeeds when k < TO and then lasts k+1
    // request cycles; otherwise it aborts after exactly TO request cycles.
    task automatic test_random();
        logic [DW-1:0] exp_rd, exp_wr, d, rv;
        logic          exp_we, ok;
        int            kind, k, reqc;
        exp_rd = 8'hC3; exp_wr = 8'h96; rv = 8'h00;
        mdr_alu_n = 1;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            d = 8'($urandom);
            k = $urandom_range(0, TO + 1);
            busALU = d; wr_start = (kind != 0); rd_start = (kind != 1); mem_ack = 0;
            exp_we = (kind != 0);
            if (exp_we) exp_wr = d;
            ok = (k < TO);
            reqc = ok ? k + 1 : TO;
            for (int i = 0; i < reqc; i++) begin
                @(negedge clk);
                wr_start = 1'($urandom_range(0, 1)); rd_start = 1'($urandom_range(0, 1));
                busALU = 8'($urandom);
                n_tests++; if (st !== {1'b1, exp_we, 1'b1, 2'b00}) begin n_fail++; $display("FAIL rand_req t=%0d i=%0d got=%b exp=%b", t, i, st, {1'b1, exp_we, 1'b1, 2'b00}); end
                n_tests++; if (mem_wdata !== exp_wr) begin n_fail++; $display("FAIL rand_wdata t=%0d got=%h exp=%h", t, mem_wdata, exp_wr); end
                if (i == k) begin
                    rv = 8'($urandom); mem_rdata = rv; mem_ack = 1;
                end else begin
                    mem_rdata = 8'($urandom); mem_ack = 0;
                end
            end
            @(negedge clk);
            rd_start = 0; wr_start = 0; mem_ack = 0;
            if (ok && !exp_we) exp_rd = rv;
            n_tests++; if (st !== {3'b000, ok, !ok}) begin n_fail++; $display("FAIL rand_end t=%0d got=%b exp=%b", t, st, {3'b000, ok, !ok}); end
            n_tests++; if (busC !== exp_rd) begin n_fail++; $display("FAIL rand_rd t=%0d got=%h exp=%h", t, busC, exp_rd); end
            if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1; mem_rdata = 8'($urandom);
                @(negedge clk);
                mem_ack = 0;
                n_tests++; if ({st, busC} !== {5'b00000, exp_rd}) begin n_fail++; $display("FAIL rand_idle_ack t=%0d got=%b/%h exp=00000/%h", t, st, busC, exp_rd); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_ack_at_limit();
        test_both_start();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdr_handshake.md
Name: mdr_handshake

Overview:
- Parametrised successor to the datapath memory data register.
- Holds one write-data word, captured from busALU, and one read-data word, returned by memory.
- Runs the memory transaction itself with a req/ack handshake, a wait-state timeout and busy/done/err status toward the control unit.
- Sits between the ALU/bus C datapath and the external data bus.

Parameters:
- DATA_WIDTH, 8: width of all data paths and both holding registers.
- TIMEOUT, 16: maximum cycles mem_req may stay high without mem_ack before abort; 0 disables timeout.
- CNT_WIDTH, 8: timeout counter width; must satisfy 2^CNT_WIDTH > TIMEOUT.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-low reset (asserted when 0), sampled on the rising clk edge.
- rd_start, input, 1: request a memory read; accepted only in IDLE.
- wr_start, input, 1: request a memory write of the busALU value; accepted only in IDLE.
- mdr_alu_n, input, 1: bus C source select; 1 selects the read register, 0 passes busALU through.
- busALU, input, DATA_WIDTH: ALU result bus.
- busC, output, DATA_WIDTH: datapath bus C.
- mem_rdata, input, DATA_WIDTH: read data from memory; valid when mem_ack is 1.
- mem_ack, input, 1: memory completes the current transfer.
- mem_req, output, 1: transfer request; held high until ack or timeout.
- mem_we, output, 1: 1 = write, 0 = read; stable while mem_req is 1.
- mem_wdata, output, DATA_WIDTH: write register contents.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse on successful completion.
- err, output, 1: one-cycle pulse on timeout abort.

Behaviour:
- Reset (rst=0 at an edge): state IDLE; rd_reg, wr_reg and timeout counter cleared to 0. Outputs after reset: mem_req=0, mem_we=0, mem_wdata=0, busy=0, done=0, err=0.
- busC: combinational, = mdr_alu_n ? rd_reg : busALU. It is not gated by state.
- mem_wdata = wr_reg at all times.
- FSM states: IDLE, RD, WR.
- IDLE:
  - wr_start=1: wr_reg<=busALU, go to WR.
  - Else rd_start=1: go to RD.
  - When both are 1 in the same cycle, the write has priority and the read is dropped.
  - mem_ack while in IDLE is ignored.
- RD: mem_req=1, mem_we=0.
  - mem_ack=1: rd_reg<=mem_rdata, done=1 next cycle, return to IDLE.
- WR: mem_req=1, mem_we=1.
  - mem_ack=1: done=1 next cycle, return to IDLE; rd_reg unchanged.
- Latency:
  - Start sampled at edge n: mem_req high from cycle n+1.
  - Fastest ack, at edge n+1: done high and busy low during cycle n+2.
  - rd_reg holds the new data from cycle n+2.
- Timeout counter:
  - Cleared on entry to RD/WR; increments on each edge where mem_req=1 and mem_ack=0.
  - When the counter equals TIMEOUT-1 and mem_ack=0: abort, err=1 next cycle, return to IDLE.
  - On abort, rd_reg and wr_reg are unchanged and done stays 0.
- Ack and timeout threshold in the same cycle: ack wins (done, not err).
- done and err are never high together. Both are registered pulses, exactly one cycle each.
- rd_start/wr_start while busy=1: ignored, not queued.
- New start in the cycle done/err is high: accepted, since the state is already IDLE.
- Reset mid-transfer: abort immediately, state IDLE, mem_req=0 in the next cycle. No done or err is produced.
- Arithmetic: data is never modified. The counter saturates at TIMEOUT-1 and never wraps.

Decomposition:
- Shared package/include mdr_pkg: state encoding localparams (IDLE=2'd0, RD=2'd1, WR=2'd2), reset value constant.
- One sub-module, mdr_timeout_cnt, holds the counter with clear/enable/expire and the TIMEOUT=0 disable logic.
- FSM, holding registers and muxing stay in mdr_handshake.

Test Plan (DATA_WIDTH=8, TIMEOUT=4):
- Reset: drive rst=0 for 2 edges mid-write -> mem_req=0, busy=0, rd_reg=0x00; busC=0x00 with mdr_alu_n=1.
- Read with ack one cycle after req, mem_rdata=0xA5 -> done pulses once, busy falls, busC=0xA5 with mdr_alu_n=1; busC=busALU=0x3C with mdr_alu_n=0.
- Write: busALU=0x5A at wr_start; change busALU to 0xFF during WR; ack after 3 wait cycles -> mem_we=1 and mem_wdata=0x5A throughout; done=1; rd_reg unchanged.
- Timeout: read with no ack -> err pulses exactly 1 cycle after the 4th req cycle, done=0, rd_reg retains its prior 0xA5.
- Ack on the same cycle the counter reaches 3 -> done=1, err=0, rd_reg=mem_rdata.
- rd_start and wr_start together in IDLE -> a write is performed (mem_we=1). Extra rd_start while busy -> no second transaction; exactly one done pulse.
